// File: rtl/cas_recorder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cas_recorder
//
// Write side of the cassette tape path. While the motor relay is on, the CoCo
// 6-bit sound DAC is squared up by a hysteresis comparator. The time between
// rising crossings is measured and classed as a bit: a short cycle (2400 Hz)
// is a 1, a long cycle (1200 Hz) is a 0, LSB first. Bits are framed into bytes
// once the 0x55 leader is seen, and each byte is written into the tape SRAM as
// a raw CAS stream.
//
// Optional build macro:
//   CAS_REC_GLITCH_FILTER_EN  the comparator must hold a new value for
//                             FILTER_LEN clocks before the level follows.
//                             This adds FILTER_LEN clocks of write latency.
//
// Ports:
//   clk       in   system clock (50 MHz)
//   reset_n   in   asynchronous active-low reset
//   arm       in   one-clock pulse, start a new recording
//   relay     in   cassette motor relay, 1 = on
//   sound     in   [5:0] DAC level, synchronous to clk
//   ram_addr  out  [15:0] SRAM write address
//   ram_data  out  [7:0]  SRAM write data
//   ram_wr    out  one-clock SRAM write strobe
//   length    out  [16:0] bytes written since arm (0..DEPTH)
//   locked    out  byte framing is locked
//   full      out  SRAM exhausted
//
// DEPTH is the SRAM size in bytes; the tape SRAM is 64 KiB.
// -----------------------------------------------------------------------------
module cas_recorder #(
  parameter int         P_MIN      = 10417,
  parameter int         P_SPLIT    = 31250,
  parameter int         P_MAX      = 62500,
  parameter logic [5:0] LVL_HI     = 6'd36,
  parameter logic [5:0] LVL_LO     = 6'd28,
  parameter int         FILTER_LEN = 16,
  parameter int         DEPTH      = 65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        arm,
  input  logic        relay,
  input  logic [5:0]  sound,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wr,
  output logic [16:0] length,
  output logic        locked,
  output logic        full
);

  localparam int            CW        = $clog2(P_MAX + 2);
  localparam logic [CW-1:0] C_MIN     = CW'(P_MIN);
  localparam logic [CW-1:0] C_SPLIT   = CW'(P_SPLIT);
  localparam logic [CW-1:0] C_SAT     = CW'(P_MAX + 1);
  localparam logic [15:0]   ADDR_LAST = 16'(DEPTH - 1);
  localparam logic [16:0]   LEN_FULL  = 17'(DEPTH);

  // Catch nonsensical parameter sets at elaboration.
  if (P_MIN < 1 || P_MIN >= P_SPLIT || P_SPLIT > P_MAX || FILTER_LEN < 1 ||
      DEPTH < 2 || DEPTH > 65536 || LVL_LO >= LVL_HI) begin : g_bad_cfg
    $error("cas_recorder: inconsistent parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Comparator (level_q is the squared-up tape signal)
  // ---------------------------------------------------------------------------
  logic level_q, level_d;
  logic level_dly_q, level_dly_d;

`ifdef CAS_REC_GLITCH_FILTER_EN
  localparam int            FW    = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] F_TOP = FW'(FILTER_LEN - 1);

  logic          cmp_q, cmp_d;
  logic [FW-1:0] flt_q, flt_d;

  // cmp_q is the raw hysteresis comparator; level_q only follows it after it
  // has disagreed with level_q for FILTER_LEN consecutive clocks.
  always_comb begin
    cmp_d = cmp_q;
    if (sound >= LVL_HI)      cmp_d = 1'b1;
    else if (sound <= LVL_LO) cmp_d = 1'b0;

    level_d = level_q;
    flt_d   = '0;
    if (cmp_q != level_q) begin
      if (flt_q == F_TOP) level_d = cmp_q;
      else                flt_d   = flt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_q <= 1'b0;
      flt_q <= '0;
    end else begin
      cmp_q <= cmp_d;
      flt_q <= flt_d;
    end
  end
`else
  // Between the two thresholds the level holds its previous value.
  always_comb begin
    level_d = level_q;
    if (sound >= LVL_HI)      level_d = 1'b1;
    else if (sound <= LVL_LO) level_d = 1'b0;
  end
`endif

  assign level_dly_d = level_q;

  logic rise;
  assign rise = level_q & ~level_dly_q;

  // ---------------------------------------------------------------------------
  // Period counter and bit classification (stage 1)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_vld_q, bit_vld_d;
  logic          bit_val_q, bit_val_d;
  logic          sil_evt;

  always_comb begin
    cnt_d     = (cnt_q == C_SAT) ? cnt_q : cnt_q + 1'b1;
    bit_vld_d = 1'b0;
    bit_val_d = bit_val_q;
    if (rise) begin
      if (cnt_q == C_SAT) begin
        // First edge after silence only starts timing.
        cnt_d = '0;
      end else if (cnt_q >= C_MIN) begin
        cnt_d     = '0;
        bit_vld_d = 1'b1;
        bit_val_d = (cnt_q < C_SPLIT);
      end
      // Too-short cycles are noise: the counter keeps running.
    end
  end

  // One-shot: only the step onto the saturation value counts as silence.
  assign sil_evt = (cnt_d == C_SAT) && (cnt_q != C_SAT);

  // ---------------------------------------------------------------------------
  // Framing FSM and shift register (stage 2)
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  sr_shift;
  logic        wr_req;

  assign sr_shift = {bit_val_q, sr_q[7:1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    wr_req  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (relay) state_d = S_HUNT;
      end
      S_HUNT: begin
        if (!relay) begin
          state_d = S_IDLE;
          sr_d    = '0;
          bcnt_d  = '0;
        end else if (bit_vld_q) begin
          sr_d = sr_shift;
          if (sr_shift == 8'h55) begin
            wr_req  = 1'b1;
            bcnt_d  = '0;
            state_d = S_LOCKED;
          end
        end
      end
      S_LOCKED: begin
        if (!relay) begin
          state_d = S_IDLE;
          sr_d    = '0;
          bcnt_d  = '0;
        end else if (sil_evt) begin
          // Partial byte is dropped; hunt for a fresh leader.
          state_d = S_HUNT;
          sr_d    = '0;
          bcnt_d  = '0;
        end else if (bit_vld_q) begin
          sr_d = sr_shift;
          if (bcnt_q == 3'd7) begin
            wr_req = 1'b1;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sr_d    = '0;
        bcnt_d  = '0;
      end
    endcase

    if (arm) begin
      state_d = relay ? S_HUNT : S_IDLE;
      sr_d    = '0;
      bcnt_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM write port
  // ---------------------------------------------------------------------------
  logic [15:0] addr_q, addr_d;
  logic [16:0] length_q, length_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  ram_data_q, ram_data_d;

  always_comb begin
    length_d = length_q;
    addr_d   = addr_q;
    // Address and length advance the cycle after the strobe; the address
    // parks on the last location instead of wrapping.
    if (ram_wr_q) begin
      length_d = length_q + 1'b1;
      if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
    end
    if (arm) begin
      length_d = '0;
      addr_d   = '0;
    end

    // length_d already includes a strobe still in flight, so a byte that
    // would overflow the SRAM never reaches the bus.
    ram_wr_d   = wr_req && !arm && (length_d != LEN_FULL);
    ram_data_d = ram_wr_d ? sr_shift : ram_data_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      bit_vld_q   <= 1'b0;
      bit_val_q   <= 1'b0;
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bcnt_q      <= '0;
      addr_q      <= '0;
      length_q    <= '0;
      ram_wr_q    <= 1'b0;
      ram_data_q  <= '0;
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
      bit_vld_q   <= bit_vld_d;
      bit_val_q   <= bit_val_d;
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      addr_q      <= addr_d;
      length_q    <= length_d;
      ram_wr_q    <= ram_wr_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_data = ram_data_q;
  assign ram_wr   = ram_wr_q;
  assign length   = length_q;
  assign locked   = (state_q == S_LOCKED);
  assign full     = (length_q == LEN_FULL);

endmodule
